// File: rtl/apb_master_if.sv
// Host request/response and APB bus signals of the two-slave APB master.
// The master modport is the controller's view.
// The slave modport is the view of the host plus the two slaves.
interface apb_master_if;
   // host side
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   // APB side
   logic        PSEL1;
   logic        PSEL2;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA1;
   logic [31:0] PRDATA2;
   logic        PREADY1;
   logic        PREADY2;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  PRDATA1, PRDATA2, PREADY1, PREADY2,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output PRDATA1, PRDATA2, PREADY1, PREADY2,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master.sv
// Single-request APB master driving two slaves.
// PADDR[31] selects the slave: 0 selects slave 1 and 1 selects slave 2.
// Each transfer runs IDLE -> SETUP -> ACCESS.
// A transfer whose slave never raises PREADY is aborted after TIMEOUT+1 ACCESS cycles,
// and that completion is reported with rsp_err=1.
// Every output comes straight from a register.
module apb_master #(
   parameter int TIMEOUT = 15
) (
   input logic          PCLK,
   input logic          PRESETn,
   apb_master_if.master bus
);
   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t            state_reg;
   logic [CNT_W-1:0]  wait_cnt_reg;
   logic              req_ready_reg;
   logic              psel1_reg;
   logic              psel2_reg;
   logic              penable_reg;
   logic              pwrite_reg;
   logic [31:0]       paddr_reg;
   logic [31:0]       pwdata_reg;
   logic              rsp_valid_reg;
   logic              rsp_err_reg;
   logic [31:0]       rsp_rdata_reg;

   logic              sel_ready;
   logic [31:0]       sel_rdata;

   // Steer the ready and read data from the slave that the latched address selects.
   // The other slave is ignored.
   always_comb begin
      sel_ready = paddr_reg[31] ? bus.PREADY2 : bus.PREADY1;
      sel_rdata = paddr_reg[31] ? bus.PRDATA2 : bus.PRDATA1;
   end

   // This block holds the transfer FSM together with all registered outputs.
   // req_ready stays 0 during reset and rises on the first edge after reset.
   // A request is accepted only while req_ready is already 1.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         req_ready_reg <= 1'b0;
         psel1_reg     <= 1'b0;
         psel2_reg     <= 1'b0;
         penable_reg   <= 1'b0;
         pwrite_reg    <= 1'b0;
         paddr_reg     <= '0;
         pwdata_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         rsp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               req_ready_reg <= 1'b1;
               if (bus.req_valid && req_ready_reg) begin
                  paddr_reg     <= bus.req_addr;
                  pwdata_reg    <= bus.req_wdata;
                  pwrite_reg    <= bus.req_write;
                  psel1_reg     <= ~bus.req_addr[31];
                  psel2_reg     <= bus.req_addr[31];
                  penable_reg   <= 1'b0;
                  wait_cnt_reg  <= '0;
                  req_ready_reg <= 1'b0;
                  state_reg     <= SETUP;
               end
            end
            SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ACCESS;
            end
            ACCESS: begin
               if (sel_ready) begin
                  if (!pwrite_reg) begin
                     rsp_rdata_reg <= sel_rdata;
                  end
                  rsp_err_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  psel1_reg     <= 1'b0;
                  psel2_reg     <= 1'b0;
                  penable_reg   <= 1'b0;
                  req_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else if (wait_cnt_reg == WAIT_MAX) begin
                  rsp_rdata_reg <= '0;
                  rsp_err_reg   <= 1'b1;
                  rsp_valid_reg <= 1'b1;
                  psel1_reg     <= 1'b0;
                  psel2_reg     <= 1'b0;
                  penable_reg   <= 1'b0;
                  req_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Drive the outputs directly from their registers.
   assign bus.req_ready = req_ready_reg;
   assign bus.PSEL1     = psel1_reg;
   assign bus.PSEL2     = psel2_reg;
   assign bus.PENABLE   = penable_reg;
   assign bus.PWRITE    = pwrite_reg;
   assign bus.PADDR     = paddr_reg;
   assign bus.PWDATA    = pwdata_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master.
// Slave 1 is a small memory model with a controllable PREADY.
// Slave 2 is driven directly by the bench.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_apb_master;
   logic        pclk;
   logic        presetn;
   logic        pready1;
   logic        pready2;
   logic [31:0] prdata2;
   logic [31:0] mem1 [0:15];
   int          n_checks;
   int          n_fail;

   apb_master_if bus_if ();

   apb_master #(.TIMEOUT(15)) dut (
      .PCLK    (pclk),
      .PRESETn (presetn),
      .bus     (bus_if)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // slave models
   assign bus_if.PREADY1 = pready1;
   assign bus_if.PRDATA1 = mem1[bus_if.PADDR[3:0]];
   assign bus_if.PREADY2 = pready2;
   assign bus_if.PRDATA2 = prdata2;

   always @(posedge pclk) begin
      if (bus_if.PSEL1 && bus_if.PENABLE && pready1 && bus_if.PWRITE)
         mem1[bus_if.PADDR[3:0]] <= bus_if.PWDATA;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      bus_if.req_valid = 1'b1;
      bus_if.req_write = wr;
      bus_if.req_addr  = addr;
      bus_if.req_wdata = data;
   endtask

   task automatic test_reset;
      presetn = 1'b1;
      #1 presetn = 1'b0;
      #1;
      n_checks++; if (bus_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", bus_if.req_ready); end
      n_checks++; if ({bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE, bus_if.PWRITE} !== 4'b0000) begin n_fail++; $display("FAIL reset_apb_ctrl: got %b expected 0000", {bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE, bus_if.PWRITE}); end
      n_checks++; if ({bus_if.PADDR, bus_if.PWDATA} !== 64'd0) begin n_fail++; $display("FAIL reset_addr_data: got %h expected 0", {bus_if.PADDR, bus_if.PWDATA}); end
      n_checks++; if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata} !== 34'd0) begin n_fail++; $display("FAIL reset_rsp: got %h expected 0", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}); end
      @(negedge pclk);
      @(negedge pclk);
      n_checks++; if (bus_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_ready: got %b expected 0", bus_if.req_ready); end
      presetn = 1'b1;
      #1;
      n_checks++; if (bus_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 0", bus_if.req_ready); end
      @(negedge pclk);
      n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_edge_ready: got %b expected 1", bus_if.req_ready); end
      n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus_if.rsp_valid); end
   endtask

   task automatic test_write;
      drive_req(1'b1, 32'h0000_0005, 32'hDEAD_BEEF);
      @(negedge pclk);  // k+1: SETUP
      bus_if.req_valid = 1'b0;
      n_checks++; if ({bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE} !== 3'b100) begin n_fail++; $display("FAIL write_setup_sel: got %b expected 100", {bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE}); end
      n_checks++; if (bus_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL write_setup_ready: got %b expected 0", bus_if.req_ready); end
      n_checks++; if ({bus_if.PWRITE, bus_if.PADDR, bus_if.PWDATA} !== {1'b1, 32'h5, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL write_setup_bus: got %h expected 10000000 5deadbeef", {bus_if.PWRITE, bus_if.PADDR, bus_if.PWDATA}); end
      @(negedge pclk);  // k+2: ACCESS
      n_checks++; if ({bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE, bus_if.rsp_valid} !== 4'b1010) begin n_fail++; $display("FAIL write_access: got %b expected 1010", {bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE, bus_if.rsp_valid}); end
      @(negedge pclk);  // k+3: response
      n_checks++; if ({bus_if.rsp_valid, bus_if.rsp_err} !== 2'b10) begin n_fail++; $display("FAIL write_rsp: got %b expected 10", {bus_if.rsp_valid, bus_if.rsp_err}); end
      n_checks++; if ({bus_if.PSEL1, bus_if.PENABLE, bus_if.req_ready} !== 3'b001) begin n_fail++; $display("FAIL write_idle: got %b expected 001", {bus_if.PSEL1, bus_if.PENABLE, bus_if.req_ready}); end
      n_checks++; if (mem1[5] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_mem: got %h expected deadbeef", mem1[5]); end
      n_checks++; if (bus_if.PADDR !== 32'h5) begin n_fail++; $display("FAIL write_paddr_retained: got %h expected 5", bus_if.PADDR); end
      @(negedge pclk);
      n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL write_rsp_pulse: got %b expected 0", bus_if.rsp_valid); end
   endtask

   task automatic test_read;
      drive_req(1'b0, 32'h0000_0005, 32'h0);
      @(negedge pclk);
      bus_if.req_valid = 1'b0;
      n_checks++; if ({bus_if.PSEL1, bus_if.PSEL2, bus_if.PWRITE} !== 3'b100) begin n_fail++; $display("FAIL read_setup: got %b expected 100", {bus_if.PSEL1, bus_if.PSEL2, bus_if.PWRITE}); end
      @(negedge pclk);
      @(negedge pclk);
      n_checks++; if ({bus_if.rsp_valid, bus_if.rsp_err} !== 2'b10) begin n_fail++; $display("FAIL read_rsp: got %b expected 10", {bus_if.rsp_valid, bus_if.rsp_err}); end
      n_checks++; if (bus_if.rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata: got %h expected deadbeef", bus_if.rsp_rdata); end
      @(negedge pclk);
   endtask

   task automatic test_slave2_wait;
      pready1 = 1'b1;  // unselected, must be ignored
      pready2 = 1'b0;
      prdata2 = 32'h1234_5678;
      drive_req(1'b0, 32'h8000_0003, 32'h0);
      @(negedge pclk);  // k+1
      bus_if.req_valid = 1'b0;
      n_checks++; if ({bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE} !== 3'b010) begin n_fail++; $display("FAIL s2_setup: got %b expected 010", {bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE}); end
      for (int c = 2; c <= 5; c++) begin
         @(negedge pclk);  // k+2 .. k+5 are ACCESS cycles
         n_checks++; if ({bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE, bus_if.rsp_valid} !== 4'b0110) begin n_fail++; $display("FAIL s2_access_k%0d: got %b expected 0110", c, {bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE, bus_if.rsp_valid}); end
      end
      pready2 = 1'b1;
      @(negedge pclk);  // k+6
      n_checks++; if ({bus_if.rsp_valid, bus_if.rsp_err} !== 2'b10) begin n_fail++; $display("FAIL s2_rsp: got %b expected 10", {bus_if.rsp_valid, bus_if.rsp_err}); end
      n_checks++; if (bus_if.rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL s2_rdata: got %h expected 12345678", bus_if.rsp_rdata); end
      n_checks++; if ({bus_if.PSEL2, bus_if.PENABLE} !== 2'b00) begin n_fail++; $display("FAIL s2_idle: got %b expected 00", {bus_if.PSEL2, bus_if.PENABLE}); end
      pready2 = 1'b0;
      @(negedge pclk);
   endtask

   task automatic test_timeout;
      int  access_cnt;
      bit  done;
      access_cnt = 0;
      done       = 1'b0;
      pready1 = 1'b0;
      drive_req(1'b0, 32'h0000_0002, 32'h0);
      @(negedge pclk);  // SETUP
      bus_if.req_valid = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge pclk);
         if (bus_if.rsp_valid) done = 1'b1;
         else if (bus_if.PENABLE) access_cnt++;
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp_seen: got %b expected 1", done); end
      n_checks++; if (access_cnt !== 16) begin n_fail++; $display("FAIL timeout_access_cycles: got %0d expected 16", access_cnt); end
      n_checks++; if ({bus_if.rsp_err, bus_if.rsp_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL timeout_err_rdata: got %h expected 100000000", {bus_if.rsp_err, bus_if.rsp_rdata}); end
      n_checks++; if ({bus_if.PSEL1, bus_if.PENABLE, bus_if.req_ready} !== 3'b001) begin n_fail++; $display("FAIL timeout_idle: got %b expected 001", {bus_if.PSEL1, bus_if.PENABLE, bus_if.req_ready}); end
      pready1 = 1'b1;
      @(negedge pclk);
   endtask

   task automatic test_reset_abort;
      drive_req(1'b1, 32'h0000_0007, 32'hA5A5_A5A5);
      @(negedge pclk);  // SETUP
      bus_if.req_valid = 1'b0;
      @(negedge pclk);  // first ACCESS
      n_checks++; if (bus_if.PENABLE !== 1'b1) begin n_fail++; $display("FAIL abort_in_access: got %b expected 1", bus_if.PENABLE); end
      presetn = 1'b0;
      #1;
      n_checks++; if ({bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE, bus_if.PWRITE, bus_if.req_ready, bus_if.rsp_valid} !== 6'b0) begin n_fail++; $display("FAIL abort_async_ctrl: got %b expected 000000", {bus_if.PSEL1, bus_if.PSEL2, bus_if.PENABLE, bus_if.PWRITE, bus_if.req_ready, bus_if.rsp_valid}); end
      n_checks++; if ({bus_if.PADDR, bus_if.PWDATA} !== 64'd0) begin n_fail++; $display("FAIL abort_async_bus: got %h expected 0", {bus_if.PADDR, bus_if.PWDATA}); end
      @(negedge pclk);
      presetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge pclk);
         n_checks++; if ({bus_if.rsp_valid, bus_if.req_ready} !== 2'b01) begin n_fail++; $display("FAIL abort_after_release_%0d: got %b expected 01", c, {bus_if.rsp_valid, bus_if.req_ready}); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_addr;
      int          phase;
      exp_addr = 32'h0;
      bus_if.req_write = 1'b0;
      bus_if.req_wdata = 32'h0;
      for (int i = 0; i < 12; i++) begin
         phase = i % 3;
         if (phase == 0) begin
            n_checks++; if ({bus_if.req_ready, bus_if.PSEL1, bus_if.PENABLE} !== 3'b100) begin n_fail++; $display("FAIL b2b_idle_%0d: got %b expected 100", i, {bus_if.req_ready, bus_if.PSEL1, bus_if.PENABLE}); end
            if (i > 0) begin
               n_checks++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp_%0d: got %b expected 1", i, bus_if.rsp_valid); end
            end
            exp_addr = 32'h0000_0100 + 32'(i * 4);
         end else if (phase == 1) begin
            n_checks++; if ({bus_if.PSEL1, bus_if.PENABLE, bus_if.req_ready, bus_if.rsp_valid} !== 4'b1000) begin n_fail++; $display("FAIL b2b_setup_%0d: got %b expected 1000", i, {bus_if.PSEL1, bus_if.PENABLE, bus_if.req_ready, bus_if.rsp_valid}); end
            n_checks++; if (bus_if.PADDR !== exp_addr) begin n_fail++; $display("FAIL b2b_setup_addr_%0d: got %h expected %h", i, bus_if.PADDR, exp_addr); end
         end else begin
            n_checks++; if ({bus_if.PSEL1, bus_if.PENABLE, bus_if.rsp_valid} !== 3'b110) begin n_fail++; $display("FAIL b2b_access_%0d: got %b expected 110", i, {bus_if.PSEL1, bus_if.PENABLE, bus_if.rsp_valid}); end
            n_checks++; if (bus_if.PADDR !== exp_addr) begin n_fail++; $display("FAIL b2b_access_addr_%0d: got %h expected %h", i, bus_if.PADDR, exp_addr); end
         end
         bus_if.req_valid = 1'b1;
         bus_if.req_addr  = 32'h0000_0100 + 32'(i * 4);
         @(negedge pclk);
      end
      bus_if.req_valid = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      pready1  = 1'b1;
      pready2  = 1'b0;
      prdata2  = 32'h0;
      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 32'h0;
      bus_if.req_wdata = 32'h0;
      test_reset();
      test_write();
      test_read();
      test_slave2_wait();
      test_timeout();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum ACCESS cycles with PREADY low before the transfer is aborted with an error.
REQ-002 SHALL have port PCLK, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port PRESETn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: the host requests a transfer.
REQ-005 SHALL have port req_ready, output, 1: the master can accept a request; high only in IDLE.
REQ-006 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, 32: transfer address.
REQ-008 SHALL have port req_wdata, input, 32: write data.
REQ-009 SHALL have port rsp_valid, output, 1: one-cycle pulse marking transfer completion.
REQ-010 SHALL have port rsp_rdata, output, 32: read data from the last completed read.
REQ-011 SHALL have port rsp_err, output, 1: the last completion was a timeout; valid with rsp_valid.
REQ-012 SHALL have port PSEL1, output, 1: selects slave 1 (PADDR[31]=0).
REQ-013 SHALL have port PSEL2, output, 1: selects slave 2 (PADDR[31]=1).
REQ-014 SHALL have port PENABLE, output, 1: APB access phase.
REQ-015 SHALL have port PWRITE, output, 1: APB direction.
REQ-016 SHALL have port PADDR, output, 32: APB address.
REQ-017 SHALL have port PWDATA, output, 32: APB write data.
REQ-018 SHALL have port PRDATA1, input, 32: read data from slave 1.
REQ-019 SHALL have port PRDATA2, input, 32: read data from slave 2.
REQ-020 SHALL have port PREADY1, input, 1: ready from slave 1.
REQ-021 SHALL have port PREADY2, input, 1: ready from slave 2.

Function
REQ-022 SHALL implement an FSM with states IDLE, SETUP and ACCESS, and SHALL drive every output from a register.
REQ-023 In IDLE, SHALL hold req_ready=1 and PSEL1=PSEL2=PENABLE=0; a rising edge with req_valid=1 SHALL latch req_addr, req_wdata and req_write into PADDR, PWDATA and PWRITE and SHALL enter SETUP.
REQ-024 In SETUP, SHALL assert exactly one PSELx per PADDR[31], hold PENABLE=0 and req_ready=0, and SHALL enter ACCESS unconditionally on the next edge.
REQ-025 In ACCESS, SHALL hold PENABLE=1 with the PSELx unchanged; the selected slave's PREADY and PRDATA SHALL be used and the unselected slave's SHALL be ignored.
REQ-026 SHALL hold PADDR, PWDATA and PWRITE stable from SETUP through the last ACCESS cycle, and SHALL retain their values in IDLE.
REQ-027 On an edge in ACCESS with the selected PREADY=1, SHALL pulse rsp_valid=1 with rsp_err=0 in the following cycle, capture the selected PRDATA into rsp_rdata for reads (unchanged for writes), drop PSELx/PENABLE and return to IDLE.
REQ-028 SHALL use a wait counter, sized by $clog2(TIMEOUT+1), cleared on SETUP entry and incremented on each ACCESS edge with the selected PREADY=0.
REQ-029 When the wait counter equals TIMEOUT and PREADY is still low, SHALL end the transfer on that edge, pulse rsp_valid=1 with rsp_err=1, set rsp_rdata=0 and return to IDLE.
REQ-030 The latency from a request edge k with a zero-wait slave SHALL be: SETUP in cycle k+1, ACCESS in cycle k+2, rsp_valid in cycle k+3; each slave wait cycle SHALL add one cycle.
REQ-031 SHALL ignore req_valid outside IDLE and SHALL never queue a request; the earliest back-to-back request SHALL be accepted in the rsp_valid cycle (IDLE).
REQ-032 SHALL keep rsp_valid low in every cycle other than the one after completion or timeout.

Reset
REQ-033 While PRESETn=0, independent of PCLK, SHALL force state=IDLE, PSEL1=PSEL2=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=rsp_err=0, rsp_rdata=0, wait counter=0 and req_ready=0.
REQ-034 After PRESETn deasserts, SHALL drive req_ready=1 from the first rising edge.
REQ-035 Reset asserted in SETUP or ACCESS SHALL abort the transfer immediately with no rsp_valid pulse.

Verification
REQ-036 Write addr 0x0000_0005, data 0xDEAD_BEEF, slave 1 zero-wait -> PSEL1 high for 2 cycles with PENABLE in the second, PSEL2=0, rsp_valid at k+3 with rsp_err=0, and slave 1 mem[5]=0xDEAD_BEEF.
REQ-037 Read addr 0x0000_0005 after that write -> rsp_rdata=0xDEAD_BEEF and rsp_err=0.
REQ-038 Read addr 0x8000_0003 with PREADY2 low for 3 ACCESS cycles and PRDATA2=0x1234_5678 -> only PSEL2 asserted, rsp_valid at k+6 and rsp_rdata=0x1234_5678.
REQ-039 PREADY held low, TIMEOUT=15 -> ACCESS lasts 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, and FSM in IDLE.
REQ-040 PRESETn pulsed low in the first ACCESS cycle -> all APB outputs 0 asynchronously, no rsp_valid pulse, and req_ready=1 after release.
REQ-041 req_valid held high continuously with changing addresses -> one request accepted per IDLE cycle only, and PADDR constant within each transfer.
